clock_set_ctrl: RTL
===================

# clock_set_ctrl

Time-setting controller for the digital clock counter core. Sequences the core between free-running and edit mode, lets the user adjust hour, minute and second in a shadow copy using debounced button pulses, and commits the new time to the core with a single load strobe. It also drives the display's edit-field indication: which field to blink and when to blank it. Sits between the button debouncers and the clock core's run/load inputs.

## Interface
- CLK_HZ, 50_000_000, clk frequency in Hz
- BLINK_HALF, 25_000_000, cycles per blink half-period (visible or blank)
- TIMEOUT_CYC, 500_000_000, idle cycles in edit mode before abort (10 s)
- clk  in  1  clock
- resetN  in  1  reset, asynchronous, active-low
- modeP  in  1  one-cycle pulse, mode button (debounced)
- incP  in  1  one-cycle pulse, increment button
- decP  in  1  one-cycle pulse, decrement button
- curSec  in  6  core seconds, 0..59
- curMin  in  6  core minutes, 0..59
- curHour  in  5  core hours, 0..23
- runEn  out  1  core count enable; 1 = clock advances
- loadEn  out  1  one-cycle strobe: core loads loadHour/loadMin/loadSec
- loadSec  out  6  shadow seconds; valid in edit mode and with loadEn
- loadMin  out  6  shadow minutes
- loadHour  out  5  shadow hours
- editField  out  2  0 none, 1 hour, 2 minute, 3 second
- blankField  out  1  1 = display blanks the field given by editField

## Operation
- States: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
- RUN: runEn=1, editField=0, blankField=0. On modeP: capture curHour/curMin/curSec into shadow, go to SET_HOUR.
- SET_x: runEn=0, editField = field code. incP adds 1 to the field and wraps 23→0 (hour) or 59→0 (min/sec). decP subtracts 1 and wraps 0→23 or 0→59. Other fields are unchanged.
- modeP advances SET_HOUR→SET_MIN→SET_SEC→COMMIT.
- COMMIT lasts one cycle: loadEn=1 with shadow values on loadX, editField=0, then go to RUN.
- Simultaneous events:
  - modeP has priority over incP/decP in the same cycle; the inc/dec is dropped.
  - incP and decP together with no modeP → no change.
  - Button pulses in COMMIT are ignored.
- Timeout: an idle counter runs in SET_x and is cleared by any modeP/incP/decP. When it reaches TIMEOUT_CYC−1, go to RUN with no loadEn (abort). The core resumes from its held value.
- Blink: the blink counter runs in SET_x. blankField toggles every BLINK_HALF cycles, starting visible (0). incP, decP and any field change restart the counter with blankField=0. Outside SET_x, the counter is cleared and blankField=0.
- Arithmetic is at field width; values above a field's maximum are impossible by construction.

## Timing
- Reset values: state RUN, runEn=1, loadEn=0, loadSec/Min/Hour=0, editField=0, blankField=0, counters 0.
- All outputs are registered. A modeP/incP/decP sampled at edge n is reflected in outputs after edge n+1 (1-cycle latency).
- modeP in RUN at edge n:
  - shadow = cur values sampled at edge n;
  - runEn=0 and editField=1 from edge n+1.
- modeP in SET_SEC at edge n: COMMIT at n+1 (loadEn=1, runEn=0). RUN at n+2 (loadEn=0, runEn=1).
- A reset mid-edit aborts immediately: outputs take reset values and no load is issued.

## Structure
- Shared package clock_pkg holds:
  - state enum (RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT);
  - field codes FLD_NONE/HOUR/MIN/SEC;
  - MAX_SEC=59, MAX_MIN=59, MAX_HOUR=23;
  - widths SEC_W=6, MIN_W=6, HOUR_W=5.
- One sub-module, edit_timer: blink counter plus idle/timeout counter, with inputs clear and enable, outputs blankField and timeout. The FSM and wrap arithmetic stay in clock_set_ctrl.

## Test plan
- Reset, then modeP at cur 12:34:56 → editField=1, shadow 12:34:56, runEn=0 one cycle later.
- In SET_HOUR at 23: incP → loadHour=0. In SET_MIN at 0: decP → loadMin=59. In SET_SEC: incP+decP together → unchanged.
- Full sequence setting 07:05:30, then modeP from SET_SEC → loadEn high exactly 1 cycle with 07:05:30, then runEn=1 the next cycle.
- No button for TIMEOUT_CYC cycles in SET_MIN (bench uses small params) → RUN, loadEn never asserted, runEn=1.
- In SET_HOUR with BLINK_HALF=4 → blankField toggles every 4 cycles. incP mid-blank → blankField=0 next cycle and the period restarts.
- modeP+incP in the same cycle in SET_HOUR → SET_MIN with hour unchanged. resetN low during SET_SEC → reset values, no loadEn.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock time-setting controller.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_HOUR,
    SET_MIN,
    SET_SEC,
    COMMIT
  } state_t;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HOUR = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_SEC  = 2'd3;

  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      SET_HOUR: return FLD_HOUR;
      SET_MIN:  return FLD_MIN;
      SET_SEC:  return FLD_SEC;
      default:  return FLD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button pulses and core time in; run/load controls and display edit hints out.
interface clock_set_ctrl_if;
  import clock_pkg::*;

  logic              modeP;
  logic              incP;
  logic              decP;
  logic [SEC_W-1:0]  curSec;
  logic [MIN_W-1:0]  curMin;
  logic [HOUR_W-1:0] curHour;
  logic              runEn;
  logic              loadEn;
  logic [SEC_W-1:0]  loadSec;
  logic [MIN_W-1:0]  loadMin;
  logic [HOUR_W-1:0] loadHour;
  logic [1:0]        editField;
  logic              blankField;

  modport master (
    output modeP, incP, decP, curSec, curMin, curHour,
    input  runEn, loadEn, loadSec, loadMin, loadHour, editField, blankField
  );

  modport slave (
    input  modeP, incP, decP, curSec, curMin, curHour,
    output runEn, loadEn, loadSec, loadMin, loadHour, editField, blankField
  );

endinterface

// File: rtl/clock_set_ctrl_edit_timer.sv
// Blink phase and idle-timeout counters for edit mode; both held at zero while disabled.
// blankField is registered; timeout is a decode of the idle counter register.
module edit_timer #(
  parameter int BLINK_HALF  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic resetN,
  input  logic enable,
  input  logic clear,
  output logic blankField,
  output logic timeout
);

  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_CYC - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          blank_q, blank_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    blank_d     = blank_q;
    if (!enable || clear) begin
      blink_cnt_d = '0;
      idle_cnt_d  = '0;
      blank_d     = 1'b0;
    end else begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blank_d     = ~blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
      // Idle count saturates; the controller leaves edit mode on the next edge.
      if (idle_cnt_q != IDLE_LAST) idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_cnt_q <= '0;
      idle_cnt_q  <= '0;
      blank_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      blank_q     <= blank_d;
    end
  end

  assign blankField = blank_q;
  assign timeout    = enable && (idle_cnt_q == IDLE_LAST);

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting FSM: edits a shadow copy of the core time and commits it with one load strobe.
// Outputs are registered from state/shadow, so a button sampled at edge n shows after edge n+1.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BLINK_HALF  = CLK_HZ / 2,
  parameter int TIMEOUT_CYC = CLK_HZ * 10
) (
  input  logic           clk,
  input  logic           resetN,
  clock_set_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [SEC_W-1:0]  sec_q, sec_d;

  logic              run_en_q, run_en_d;
  logic              load_en_q, load_en_d;
  logic [1:0]        edit_field_q, edit_field_d;
  logic              blank_field_q, blank_field_d;
  logic [HOUR_W-1:0] load_hour_q;
  logic [MIN_W-1:0]  load_min_q;
  logic [SEC_W-1:0]  load_sec_q;

  logic in_set, any_btn, adjust, timer_blank, timer_timeout;

  function automatic logic [SEC_W-1:0] step_60(input logic [SEC_W-1:0] v, input logic up,
                                              input logic [SEC_W-1:0] max);
    if (up) return (v == max) ? '0 : v + 1'b1;
    else    return (v == '0) ? max : v - 1'b1;
  endfunction

  function automatic logic [HOUR_W-1:0] step_hour(input logic [HOUR_W-1:0] v, input logic up);
    if (up) return (v == MAX_HOUR) ? '0 : v + 1'b1;
    else    return (v == '0) ? MAX_HOUR : v - 1'b1;
  endfunction

  assign in_set  = (state_q == SET_HOUR) || (state_q == SET_MIN) || (state_q == SET_SEC);
  assign any_btn = bus.modeP || bus.incP || bus.decP;
  // Opposing presses in the same cycle cancel out.
  assign adjust  = bus.incP ^ bus.decP;

  edit_timer #(
    .BLINK_HALF  (BLINK_HALF),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_edit_timer (
    .clk        (clk),
    .resetN     (resetN),
    .enable     (in_set),
    .clear      (any_btn),
    .blankField (timer_blank),
    .timeout    (timer_timeout)
  );

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    unique case (state_q)
      RUN: begin
        if (bus.modeP) begin
          state_d = SET_HOUR;
          hour_d  = bus.curHour;
          min_d   = bus.curMin;
          sec_d   = bus.curSec;
        end
      end
      SET_HOUR: begin
        if (bus.modeP)                      state_d = SET_MIN;
        else if (adjust)                    hour_d  = step_hour(hour_q, bus.incP);
        else if (timer_timeout && !any_btn) state_d = RUN;
      end
      SET_MIN: begin
        if (bus.modeP)                      state_d = SET_SEC;
        else if (adjust)                    min_d   = step_60(min_q, bus.incP, MAX_MIN);
        else if (timer_timeout && !any_btn) state_d = RUN;
      end
      SET_SEC: begin
        if (bus.modeP)                      state_d = COMMIT;
        else if (adjust)                    sec_d   = step_60(sec_q, bus.incP, MAX_SEC);
        else if (timer_timeout && !any_btn) state_d = RUN;
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    run_en_d      = (state_q == RUN);
    load_en_d     = (state_q == COMMIT);
    edit_field_d  = field_of(state_q);
    blank_field_d = timer_blank && in_set;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= RUN;
      hour_q        <= '0;
      min_q         <= '0;
      sec_q         <= '0;
      run_en_q      <= 1'b1;
      load_en_q     <= 1'b0;
      edit_field_q  <= FLD_NONE;
      blank_field_q <= 1'b0;
      load_hour_q   <= '0;
      load_min_q    <= '0;
      load_sec_q    <= '0;
    end else begin
      state_q       <= state_d;
      hour_q        <= hour_d;
      min_q         <= min_d;
      sec_q         <= sec_d;
      run_en_q      <= run_en_d;
      load_en_q     <= load_en_d;
      edit_field_q  <= edit_field_d;
      blank_field_q <= blank_field_d;
      load_hour_q   <= hour_q;
      load_min_q    <= min_q;
      load_sec_q    <= sec_q;
    end
  end

  assign bus.runEn      = run_en_q;
  assign bus.loadEn     = load_en_q;
  assign bus.editField  = edit_field_q;
  assign bus.blankField = blank_field_q;
  assign bus.loadHour   = load_hour_q;
  assign bus.loadMin    = load_min_q;
  assign bus.loadSec    = load_sec_q;

endmodule
